pwm_hbridge_driver: RTL
=======================

PWM_HBRIDGE_DRIVER -- requirements
Module: pwm_hbridge_driver

Interface
REQ-001 Parameter PERIOD, default 800, counts of CLK per PWM period (20 kHz at 16 MHz); legal range 2..2^23.
REQ-002 Parameter DEADTIME, default 16, CLK cycles of forced-off time on direction reversal; legal range 1..PERIOD-1.
REQ-003 CLK  input  1  system clock, 16 MHz; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  synchronous output enable; low forces the bridge off.
REQ-006 duty  input  24  signed two's-complement command from the PID stage; sign selects direction, magnitude selects on-time.
REQ-007 pwm  output  1  registered gate drive, high during on-time.
REQ-008 dir  output  1  registered direction: 0 = forward (duty >= 0), 1 = reverse (duty < 0).
REQ-009 period_tick  output  1  one-cycle pulse, high while cnt == PERIOD-1; duty-sample strobe.

Function
REQ-010 Free-running counter cnt SHALL count 0..PERIOD-1 and wrap to 0; it runs regardless of enable or state.
REQ-011 Magnitude SHALL be |duty| saturated to PERIOD; duty = -2^23 SHALL give magnitude PERIOD without overflow.
REQ-012 Sign request SHALL be duty[23]; duty = 0 SHALL give magnitude 0 and leave the current dir unchanged (no reversal requested).
REQ-013 duty SHALL be sampled only on the cycle cnt == PERIOD-1 into shadow registers mag_s and sign_s; duty changes at any other cycle SHALL have no effect.
REQ-014 The state machine SHALL have states IDLE, RUN and DT (dead-time).
REQ-015 IDLE: pwm low. Transition to RUN at the sample cycle with enable high and no sign change pending. Transition to DT at the sample cycle with enable high and a sign change pending.
REQ-016 RUN, on a sample cycle:
  - sign_s != dir and mag_s != 0 -> DT;
  - otherwise remain in RUN.
REQ-017 DT: pwm low for exactly DEADTIME cycles with dir held. dir SHALL then toggle to sign_s in the same cycle the state moves to RUN. The remainder of that period SHALL have pwm low; the on-time resumes at the next cnt == 0.
REQ-018 In RUN, pwm SHALL be registered as (cnt < mag_s), giving exactly mag_s consecutive high cycles per period, lagging cnt by one cycle.
  - mag_s = PERIOD: pwm continuously high.
  - mag_s = 0: pwm continuously low.
REQ-019 A sign change that is requested and then withdrawn before the next sample cycle SHALL be ignored.
REQ-020 enable low in any state SHALL force pwm low on the next CLK edge and move the state to IDLE; dir SHALL hold its value.
REQ-021 enable low and a sample cycle coinciding: enable SHALL win (IDLE).
REQ-022 A new sign change arriving while in DT SHALL be evaluated only at the next sample cycle after DT completes.
REQ-023 period_tick SHALL be decoded from cnt and SHALL be independent of enable and state.
REQ-024 pwm and dir SHALL be glitch-free flop outputs; pwm and a dir change SHALL never be high in the same cycle.

Reset
REQ-025 While reset is high, asynchronously:
  - cnt = 0, mag_s = 0, sign_s = 0;
  - state = IDLE;
  - pwm = 0, dir = 0, period_tick = 0.
REQ-026 On reset release, operation SHALL restart from cnt = 0. Reset mid-pulse SHALL drop pwm immediately, with no dead-time sequence.

Verification (PERIOD = 800, DEADTIME = 16)
REQ-027 enable = 1, duty = +200 -> from the first period after sampling, pwm high 200 of every 800 cycles, dir = 0, period_tick once per 800 cycles.
REQ-028 Saturation:
  - duty = +5000 -> pwm continuously high, dir = 0;
  - duty = -8388608 -> pwm continuously high, dir = 1;
  - duty = 0 -> pwm low, dir unchanged.
REQ-029 Reversal, duty +200 -> -300 -> at the sample cycle state = DT; pwm low 16 cycles, then dir = 1 with pwm low for the rest of that period; next period pwm high 300 cycles.
REQ-030 Mid-period change, duty +200 -> +600 at cnt = 100 -> current period still 200 high; next period 600 high.
REQ-031 Enable and reset mid-pulse:
  - enable deasserted at cnt = 50, duty = +400 -> pwm low next edge, dir held; re-enable -> on-time resumes only after the next sample cycle.
  - reset asserted mid-pulse -> pwm = 0, dir = 0 asynchronously, without waiting for a CLK edge.

Source files
------------

// File: rtl/pwm_hbridge_driver.sv
`default_nettype none
// ============================================================================
// Module   : pwm_hbridge_driver
// Brief    : Sign/magnitude PWM generator for an H-bridge with dead-time
//            insertion on direction reversal.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_hbridge_driver #(
    parameter int PERIOD   = 800,
    parameter int DEADTIME = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] duty,
    output logic        pwm,
    output logic        dir,
    output logic        period_tick
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_RUN      = 2'd1;
    localparam logic [1:0]  c_DT       = 2'd2;
    localparam logic [23:0] c_PERIOD   = 24'(PERIOD);
    localparam logic [23:0] c_CNT_LAST = 24'(PERIOD - 1);
    localparam logic [23:0] c_DT_LAST  = 24'(DEADTIME - 1);

    logic [23:0] cnt_q, cnt_d;
    logic [23:0] mag_s_q, mag_s_d;
    logic [23:0] dt_q, dt_d;
    logic        sign_s_q, sign_s_d;
    logic        pwm_q, pwm_d;
    logic        dir_q, dir_d;
    logic        blank_q, blank_d;
    logic [1:0]  state_q, state_d;

    logic        sample;
    logic [23:0] duty_abs;
    logic [23:0] mag_n;
    logic        sign_n;
    logic        rev_n;

    // Magnitude is formed unsigned, so -2^23 negates to exactly 2^23 without overflow.
    always_comb begin
        sample   = (cnt_q == c_CNT_LAST);
        duty_abs = duty[23] ? (~duty + 24'd1) : duty;
        mag_n    = (duty_abs > c_PERIOD) ? c_PERIOD : duty_abs;
        sign_n   = (duty == 24'd0) ? dir_q : duty[23];
        rev_n    = (sign_n != dir_q) && (mag_n != 24'd0);
    end

    // Transition decisions at the sample edge use the values being latched
    // into the shadow registers on that same edge.
    always_comb begin
        cnt_d    = sample ? 24'd0 : cnt_q + 24'd1;
        mag_s_d  = sample ? mag_n : mag_s_q;
        sign_s_d = sample ? sign_n : sign_s_q;
        state_d  = state_q;
        dir_d    = dir_q;
        blank_d  = sample ? 1'b0 : blank_q;
        dt_d     = 24'd0;

        case (state_q)
            c_IDLE: begin
                if (sample && enable) begin
                    state_d = rev_n ? c_DT : c_RUN;
                end
            end
            c_RUN: begin
                if (sample && rev_n) begin
                    state_d = c_DT;
                end
            end
            c_DT: begin
                dt_d = dt_q + 24'd1;
                if (dt_q == c_DT_LAST) begin
                    state_d = c_RUN;
                    dir_d   = sign_s_q;
                    blank_d = 1'b1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (!enable) begin
            state_d = c_IDLE;
            dir_d   = dir_q;
        end

        // Gate with both current and next state so pwm is low on every
        // edge that enters or leaves RUN; blank holds off the rest of a
        // period that began in dead-time.
        pwm_d = (state_q == c_RUN) && (state_d == c_RUN) && !blank_q
                && (cnt_q < mag_s_q);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q    <= 24'd0;
            mag_s_q  <= 24'd0;
            sign_s_q <= 1'b0;
            dt_q     <= 24'd0;
            state_q  <= c_IDLE;
            pwm_q    <= 1'b0;
            dir_q    <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mag_s_q  <= mag_s_d;
            sign_s_q <= sign_s_d;
            dt_q     <= dt_d;
            state_q  <= state_d;
            pwm_q    <= pwm_d;
            dir_q    <= dir_d;
            blank_q  <= blank_d;
        end
    end

    assign pwm         = pwm_q;
    assign dir         = dir_q;
    assign period_tick = sample;

endmodule
`default_nettype wire
